// File: rtl/trap_pkg.sv
// trap_pkg: shared FSM states, mstatus field positions, privilege encodings and cause codes for trap_ctrl.
package trap_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ENTER, S_VECTOR, S_DONE, S_RET, S_RJUMP} state_t;
    localparam int MIE_BIT = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO = 11;
    localparam int MPP_HI = 12;
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;
endpackage

// File: rtl/trap_vector_calc.sv
// trap_vector_calc: mtvec/cause -> trap target PC; vectored interrupt mode only when TRAP_CTRL_IRQ_EN is defined.
module trap_vector_calc import trap_pkg::*; #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mtvec,
    input  logic            irq,
    input  logic [3:0]      code,
    output logic [XLEN-1:0] pc
);
    logic [XLEN-1:0] base;
    assign base = {mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_CTRL_IRQ_EN
    assign pc = (irq && mtvec[1:0] == MTVEC_VECTORED) ? base + XLEN'({code, 2'b00}) : base;
`else
    logic unused_vec;
    assign unused_vec = &{1'b0, mtvec[1:0], irq, code};
    assign pc = base;
`endif
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap entry / MRET sequencer feeding the CSR file and fetch redirect.
// Interrupt acceptance and vectored mtvec are enabled by defining TRAP_CTRL_IRQ_EN.
module trap_ctrl import trap_pkg::*; #(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_req,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_val,
    input  logic            mret_req,
    input  logic [XLEN-1:0] pc_addr,
    input  logic [XLEN-1:0] mstatus_current,
    input  logic [XLEN-1:0] mtvec_trap,
    input  logic [XLEN-1:0] mepc_out,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic            trap_taken,
    output logic            trap_done,
    output logic            mret,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mcause_next,
    output logic [XLEN-1:0] mtval_next,
    output logic [XLEN-1:0] mstatus_next,
    output logic [1:0]      priv_lvl,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            stall
);
    state_t state, state_d;
    logic irq_take;
    logic [3:0] irq_code;
    logic [XLEN-1:0] trap_ms, ret_ms, vec_pc;
    logic unused_in;
    assign unused_in = &{1'b0, pc_addr[1:0]};
`ifdef TRAP_CTRL_IRQ_EN
    assign irq_code = irq_ext ? CAUSE_MEI : CAUSE_MTI;
    assign irq_take = (irq_ext || irq_timer) &&
                      ((priv_lvl == PRIV_M && mstatus_current[MIE_BIT]) || priv_lvl < PRIV_M);
`else
    logic unused_irq;
    assign unused_irq = &{1'b0, irq_timer, irq_ext};
    assign irq_code = '0;
    assign irq_take = 1'b0;
`endif
    assign stall = state != S_IDLE;
    trap_vector_calc #(.XLEN(XLEN)) u_vec (
        .mtvec(mtvec_trap),
        .irq  (mcause_next[XLEN-1]),
        .code (mcause_next[3:0]),
        .pc   (vec_pc)
    );
    always_comb begin
        state_d = S_IDLE;
        case (state)
            S_IDLE:   state_d = (exc_req || irq_take) ? S_ENTER : mret_req ? S_RET : S_IDLE;
            S_ENTER:  state_d = S_VECTOR;
            S_VECTOR: state_d = S_DONE;
            S_RET:    state_d = S_RJUMP;
            default:  state_d = S_IDLE;
        endcase
        trap_ms = mstatus_current;
        trap_ms[MPIE_BIT] = mstatus_current[MIE_BIT];
        trap_ms[MIE_BIT] = 1'b0;
        trap_ms[MPP_HI:MPP_LO] = priv_lvl;
        ret_ms = mstatus_current;
        ret_ms[MIE_BIT] = mstatus_current[MPIE_BIT];
        ret_ms[MPIE_BIT] = 1'b1;
        ret_ms[MPP_HI:MPP_LO] = PRIV_U;
    end
    // Pulses are derived from the next state so each is a registered single-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            priv_lvl <= RESET_PRIV;
            trap_taken <= 1'b0;
            trap_done <= 1'b0;
            mret <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc <= '0;
            mepc_next <= '0;
            mcause_next <= '0;
            mtval_next <= '0;
            mstatus_next <= '0;
        end else begin
            state <= state_d;
            trap_taken <= state_d == S_ENTER;
            trap_done <= state_d == S_DONE;
            mret <= state_d == S_RET;
            redirect_valid <= state_d == S_VECTOR || state_d == S_RJUMP;
            if (state_d == S_ENTER) begin
                mepc_next <= {pc_addr[XLEN-1:2], 2'b00};
                mcause_next <= {!exc_req, {(XLEN-5){1'b0}}, exc_req ? exc_code : irq_code};
                mtval_next <= exc_req ? exc_val : '0;
                mstatus_next <= trap_ms;
                priv_lvl <= PRIV_M;
            end
            if (state_d == S_RET) begin
                mstatus_next <= ret_ms;
                priv_lvl <= mstatus_current[MPP_HI:MPP_LO];
            end
            if (state_d == S_VECTOR) redirect_pc <= vec_pc;
            if (state_d == S_RJUMP) redirect_pc <= mepc_out;
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: randomized self-checking bench for trap_ctrl against a transaction-level reference model.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic exc_req = 1'b0, mret_req = 1'b0, irq_timer = 1'b0, irq_ext = 1'b0;
    logic [3:0] exc_code = '0;
    logic [63:0] exc_val = '0, pc_addr = '0, mstatus_current = '0, mtvec_trap = '0, mepc_out = '0;
    logic trap_taken, trap_done, mret, redirect_valid, stall;
    logic [63:0] mepc_next, mcause_next, mtval_next, mstatus_next, redirect_pc;
    logic [1:0] priv_lvl;
    int checks = 0;
    int errors = 0;
    logic [1:0] m_priv = 2'b11;
    logic [63:0] m_mepc = '0, m_mcause = '0, m_mtval = '0, m_mstatus = '0;

    trap_ctrl #(.XLEN(64), .RESET_PRIV(2'b11)) dut (
        .clk(clk), .rst(rst), .exc_req(exc_req), .exc_code(exc_code), .exc_val(exc_val),
        .mret_req(mret_req), .pc_addr(pc_addr), .mstatus_current(mstatus_current),
        .mtvec_trap(mtvec_trap), .mepc_out(mepc_out), .irq_timer(irq_timer), .irq_ext(irq_ext),
        .trap_taken(trap_taken), .trap_done(trap_done), .mret(mret), .mepc_next(mepc_next),
        .mcause_next(mcause_next), .mtval_next(mtval_next), .mstatus_next(mstatus_next),
        .priv_lvl(priv_lvl), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pulses"}, 64'({trap_taken, redirect_valid, trap_done, mret}), 64'h0);
        chk({tag, "_stall"}, 64'(stall), 64'h0);
        chk({tag, "_priv"}, 64'(priv_lvl), 64'h3);
        chk({tag, "_mepc"}, mepc_next, 64'h0);
        chk({tag, "_mcause"}, mcause_next, 64'h0);
        chk({tag, "_mstatus"}, mstatus_next, 64'h0);
        chk({tag, "_rpc"}, redirect_pc, 64'h0);
    endtask

    // One request presented for a single sampling edge (held `hold` cycles), then four cycles observed.
    task automatic txn(input bit e, input logic [3:0] code, input logic [63:0] val, input bit m,
                       input logic [63:0] pc, input logic [63:0] ms, input logic [63:0] tv,
                       input logic [63:0] mp, input bit it, input bit ie, input int hold);
        int kind;
        int slen;
        int h;
        bit irq;
        logic [3:0] c;
        logic [63:0] exp_pc;
        logic [3:0] pat[4];
        @(negedge clk);
        exc_req = e; exc_code = code; exc_val = val; mret_req = m; pc_addr = pc;
        mstatus_current = ms; mtvec_trap = tv; mepc_out = mp; irq_timer = it; irq_ext = ie;
        irq = 1'b0;
        c = code;
        exp_pc = '0;
`ifdef TRAP_CTRL_IRQ_EN
        if (!e && (it || ie) && ((m_priv == 2'b11 && ms[3]) || m_priv < 2'b11)) begin
            irq = 1'b1;
            c = ie ? 4'd11 : 4'd7;
        end
`endif
        kind = (e || irq) ? 1 : m ? 2 : 0;
        h = (kind == 1) ? hold : 1;
        if (kind == 1) begin
            m_mepc = pc & ~64'h3;
            m_mcause = (irq ? 64'h8000_0000_0000_0000 : 64'h0) + 64'(c);
            m_mtval = irq ? 64'h0 : val;
            m_mstatus = (ms & ~64'h1888) | (ms[3] ? 64'h80 : 64'h0) | (64'(m_priv) << 11);
            exp_pc = (tv & ~64'h3) + ((irq && tv[1:0] == 2'b01) ? 64'(c) * 4 : 64'h0);
            m_priv = 2'b11;
            pat = '{4'b1000, 4'b0100, 4'b0010, 4'b0000};
            slen = 3;
        end else if (kind == 2) begin
            m_mstatus = (ms & ~64'h1888) | (ms[7] ? 64'h8 : 64'h0) | 64'h80;
            exp_pc = mp;
            m_priv = ms[12:11];
            pat = '{4'b0001, 4'b0100, 4'b0000, 4'b0000};
            slen = 2;
        end else begin
            pat = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
            slen = 0;
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pulses_k%0d_kind%0d", k, kind),
                64'({trap_taken, redirect_valid, trap_done, mret}), 64'(pat[k-1]));
            chk($sformatf("stall_k%0d", k), 64'(stall), 64'(k <= slen));
            if (k == 1) begin
                chk("mepc_next", mepc_next, m_mepc);
                chk("mcause_next", mcause_next, m_mcause);
                chk("mtval_next", mtval_next, m_mtval);
                chk("mstatus_next", mstatus_next, m_mstatus);
            end
            if (k == 2 && kind != 0) chk("redirect_pc", redirect_pc, exp_pc);
            if (k == 3) chk("priv_lvl", 64'(priv_lvl), 64'(m_priv));
            if (k >= h) begin
                exc_req = 1'b0; mret_req = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
            end
        end
    endtask

    initial begin
        bit e, m, it, ie;
        logic [63:0] ms;
        int sel;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        // MRET back to U, then U-mode illegal-instruction trap with a held (ignored) second request.
        txn(0, 4'd0, 64'h0, 1, 64'h2000, 64'h80, 64'h0, 64'h1004, 0, 0, 1);
        txn(1, 4'd2, 64'hdead, 0, 64'h1000, 64'h8, 64'h8000, 64'h0, 0, 0, 2);
        txn(1, 4'd2, 64'hbeef, 1, 64'h3003, 64'h1888, 64'h9002, 64'h4000, 0, 0, 1);
        // Reset asserted in the VECTOR cycle.
        @(negedge clk);
        exc_req = 1'b1; exc_code = 4'd5; exc_val = 64'h55; pc_addr = 64'h7000;
        mstatus_current = 64'h8; mtvec_trap = 64'hA000;
        @(posedge clk);
        #1;
        exc_req = 1'b0;
        @(posedge clk);
        #1;
        chk("vector_redirect", 64'(redirect_valid), 64'h1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_priv = 2'b11; m_mepc = '0; m_mcause = '0; m_mtval = '0; m_mstatus = '0;
        @(posedge clk);
        #1;
        chk("post_rst_pulses", 64'({trap_taken, redirect_valid, trap_done, mret}), 64'h0);
        // External interrupt with vectored mtvec, then blocked by MIE=0 in M.
        txn(0, 4'd0, 64'h0, 0, 64'h5000, 64'h1808, 64'h8001, 64'h0, 0, 1, 1);
        txn(0, 4'd0, 64'h0, 0, 64'h5004, 64'h1800, 64'h8001, 64'h0, 1, 1, 1);
        for (int n = 0; n < 300; n++) begin
            e = $urandom_range(0, 9) < 4;
            m = (m_priv == 2'b11) ? ($urandom_range(0, 9) < 5) : (e && $urandom_range(0, 1) == 1);
            it = $urandom_range(0, 9) < 3;
            ie = $urandom_range(0, 9) < 3;
            ms = {$urandom, $urandom};
            sel = $urandom_range(0, 2);
            ms[12:11] = (sel == 2) ? 2'b11 : 2'(sel);
            txn(e, 4'($urandom), {$urandom, $urandom}, m, {$urandom, $urandom}, ms,
                {$urandom, $urandom}, {$urandom, $urandom}, it, ie, $urandom_range(1, 2));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
